// File: rtl/updown_counter_param.sv
// updown_counter_param
// Parametrised synchronous up/down counter with count enable, direction
// select, parallel load, programmable modulus and wrap/saturate behaviour.
// Q, ovf and lerr come straight from flops.
// tc is the only combinational output: it flags the cycle before an
// end-of-range edge.
module updown_counter_param #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E,
    input  logic             x,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf,
    output logic             lerr
);

    // Highest legal count. Arithmetic stays inside 0..MAX, so a
    // non-power-of-two modulus never lets Q escape the range.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_r;
    logic             ovf_r;
    logic             lerr_r;

    logic [WIDTH-1:0] q_next_s;
    logic             ovf_next_s;
    logic             lerr_next_s;
    logic             at_max_s;
    logic             at_zero_s;

    assign at_max_s  = (q_r == MAX);
    assign at_zero_s = (q_r == ZERO);

    // Next-state selection: load has priority over counting; an idle cycle holds.
    always_comb begin
        q_next_s    = q_r;
        ovf_next_s  = 1'b0;
        lerr_next_s = 1'b0;
        if (load) begin
            if (din > MAX) begin
                q_next_s    = MAX;
                lerr_next_s = 1'b1;
            end else begin
                q_next_s = din;
            end
        end else if (E) begin
            case (x)
                1'b1: begin
                    if (at_max_s) begin
                        q_next_s   = SATURATE ? MAX : ZERO;
                        ovf_next_s = 1'b1;
                    end else begin
                        q_next_s = q_r + ONE;
                    end
                end
                1'b0: begin
                    if (at_zero_s) begin
                        q_next_s   = SATURATE ? ZERO : MAX;
                        ovf_next_s = 1'b1;
                    end else begin
                        q_next_s = q_r - ONE;
                    end
                end
                default: begin
                    q_next_s = q_r;
                end
            endcase
        end else begin
            q_next_s = q_r;
        end
    end

    // State and event-pulse registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= ZERO;
            ovf_r  <= 1'b0;
            lerr_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            ovf_r  <= ovf_next_s;
            lerr_r <= lerr_next_s;
        end
    end

    // Terminal count: this cycle's edge will wrap or saturate.
    always_comb begin
        tc = E & ~load & ((x & at_max_s) | (~x & at_zero_s));
    end

    assign Q    = q_r;
    assign ovf  = ovf_r;
    assign lerr = lerr_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed testbench for updown_counter_param.
// Three instances share the same stimulus:
//   - modulus 16, wrap
//   - modulus 10, wrap
//   - modulus 10, saturate
// Each test step checks only the instance it targets.
module tb_updown_counter_param;

    logic       clk;
    logic       rst;
    logic       E;
    logic       x;
    logic       load;
    logic [3:0] din;

    logic [3:0] q16;
    logic       tc16;
    logic       ovf16;
    logic       lerr16;
    logic [3:0] q10;
    logic       tc10;
    logic       ovf10;
    logic       lerr10;
    logic [3:0] q10s;
    logic       tc10s;
    logic       ovf10s;
    logic       lerr10s;

    int n_checks;
    int n_fail;

    updown_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut16 (
        .clk(clk), .rst(rst), .E(E), .x(x), .load(load), .din(din),
        .Q(q16), .tc(tc16), .ovf(ovf16), .lerr(lerr16)
    );

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut10 (
        .clk(clk), .rst(rst), .E(E), .x(x), .load(load), .din(din),
        .Q(q10), .tc(tc10), .ovf(ovf10), .lerr(lerr10)
    );

    updown_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut10s (
        .clk(clk), .rst(rst), .E(E), .x(x), .load(load), .din(din),
        .Q(q10s), .tc(tc10s), .ovf(ovf10s), .lerr(lerr10s)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int exp_q;

        n_checks = 0;
        n_fail   = 0;

        // Test 1: reset overrides load and count enable.
        rst  = 1'b1;
        E    = 1'b1;
        x    = 1'b1;
        load = 1'b1;
        din  = 4'd9;
        tick();
        tick();
        check("rst_q16", 16'(q16), 16'd0);
        check("rst_ovf16", 16'(ovf16), 16'd0);
        check("rst_lerr16", 16'(lerr16), 16'd0);
        check("rst_q10", 16'(q10), 16'd0);

        // Test 2: count up through modulus 10 and wrap back to 0.
        rst   = 1'b0;
        load  = 1'b0;
        E     = 1'b1;
        x     = 1'b1;
        exp_q = 0;
        #1;
        for (int i = 0; i < 10; i++) begin
            check("up_tc", 16'(tc10), (exp_q == 9) ? 16'd1 : 16'd0);
            tick();
            exp_q = (exp_q + 1) % 10;
            check("up_q", 16'(q10), 16'(exp_q));
            check("up_ovf", 16'(ovf10), (exp_q == 0) ? 16'd1 : 16'd0);
        end

        // Test 3: count down from 0 wraps to 9, then hold with E low.
        x = 1'b0;
        #1;
        check("dn_tc", 16'(tc10), 16'd1);
        tick();
        check("dn_q", 16'(q10), 16'd9);
        check("dn_ovf", 16'(ovf10), 16'd1);
        E = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", 16'(q10), 16'd9);
            check("hold_ovf", 16'(ovf10), 16'd0);
        end
        check("hold_tc", 16'(tc10), 16'd0);

        // Test 4: saturating instance pins at 9 and pulses ovf on each pinned edge.
        load = 1'b1;
        din  = 4'd8;
        tick();
        check("sat_load_q", 16'(q10s), 16'd8);
        load = 1'b0;
        E    = 1'b1;
        x    = 1'b1;
        tick();
        check("sat_q1", 16'(q10s), 16'd9);
        check("sat_ovf1", 16'(ovf10s), 16'd0);
        check("sat_tc", 16'(tc10s), 16'd1);
        tick();
        check("sat_q2", 16'(q10s), 16'd9);
        check("sat_ovf2", 16'(ovf10s), 16'd1);
        tick();
        check("sat_q3", 16'(q10s), 16'd9);
        check("sat_ovf3", 16'(ovf10s), 16'd1);
        x = 1'b0;
        tick();
        check("sat_dn_q", 16'(q10s), 16'd8);
        check("sat_dn_ovf", 16'(ovf10s), 16'd0);

        // Test 5: in-range load, out-of-range clamp, and load overriding count at MAX.
        load = 1'b1;
        E    = 1'b1;
        x    = 1'b1;
        din  = 4'd4;
        tick();
        check("ld_q", 16'(q10), 16'd4);
        check("ld_lerr", 16'(lerr10), 16'd0);
        din = 4'd13;
        tick();
        check("ldbig_q", 16'(q10), 16'd9);
        check("ldbig_lerr", 16'(lerr10), 16'd1);
        load = 1'b0;
        E    = 1'b0;
        tick();
        check("lerr_pulse", 16'(lerr10), 16'd0);
        check("ldbig_hold", 16'(q10), 16'd9);
        load = 1'b1;
        E    = 1'b1;
        x    = 1'b1;
        din  = 4'd3;
        #1;
        check("ld_tc_masked", 16'(tc10), 16'd0);
        tick();
        check("ldmax_q", 16'(q10), 16'd3);
        check("ldmax_ovf", 16'(ovf10), 16'd0);

        // Test 6: direction toggling every edge, then reset in mid-count.
        din = 4'd5;
        tick();
        check("mid_load", 16'(q10), 16'd5);
        load = 1'b0;
        E    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();
            check("tog_q", 16'(q10), (i % 2 == 0) ? 16'd6 : 16'd5);
        end
        rst = 1'b1;
        x   = 1'b1;
        tick();
        check("mid_rst_q", 16'(q10), 16'd0);
        check("mid_rst_ovf", 16'(ovf10), 16'd0);
        rst = 1'b0;
        tick();
        check("resume_q1", 16'(q10), 16'd1);
        tick();
        check("resume_q2", 16'(q10), 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
